// File: rtl/dsm_dem_io_ctrl.sv
// Pad-to-core interface for an N-channel sigma-delta modulator / DEM core.
// Optional loopback path is compiled in when DSM_DEM_IO_LOOPBACK_EN is defined.
module dsm_dem_io_ctrl #(
    parameter int NCH         = 2,
    parameter int IW          = 24,
    parameter int OW          = 16,
    parameter int FRAME_DIV   = 512,
    parameter int SYNC_STAGES = 2,
    parameter int CNTW        = 8,
    parameter int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                mclk512,
    input  logic                reset,
    input  logic [NCH*IW-1:0]   pad_chan,
    input  logic [CW-1:0]       pad_rot,
    input  logic                pad_clr,
    input  logic                pad_ditheroff,
    input  logic [1:0]          pad_dem_count,
    input  logic                pad_loopback,
    output logic [NCH*IW-1:0]   core_chan,
    output logic                core_frame,
    output logic                core_clr,
    output logic                core_ditheroff,
    output logic [1:0]          core_dem_count,
    input  logic [NCH-1:0]      core_ovfl,
    input  logic [NCH*OW-1:0]   core_dem_out,
    output logic                pad_ovfl,
    output logic [NCH-1:0]      pad_ovfl_chan,
    output logic [CNTW-1:0]     pad_ovfl_cnt,
    output logic [NCH*OW-1:0]   pad_dem_out
);

    localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
`ifdef DSM_DEM_IO_LOOPBACK_EN
    localparam int SW = CW + 5;
`else
    localparam int SW = CW + 4;
`endif

    logic [SW-1:0]       sync_in;
    logic [SW-1:0]       sync_q [SYNC_STAGES];
    logic [SW-1:0]       synced;
    logic [1:0]          s_dem;
    logic                s_dith;
    logic                s_clr;
    logic [CW-1:0]       s_rot;
    logic                ovfl_en;
    logic                clr_prev;
    logic                clr_edge;
    logic [FCW-1:0]      frame_cnt;
    logic                fs;
    logic [CW-1:0]       rot_q;
    logic [CW-1:0]       rot_d;
    logic [NCH*IW-1:0]   in_hold;
    logic [NCH*OW-1:0]   dem_next;
    logic [NCH-1:0]      ovfl_set;
    logic                ovfl_any;

    function automatic int wrap_idx(input int v);
        if (v < 0)
            return v + NCH;
        else if (v >= NCH)
            return v - NCH;
        else
            return v;
    endfunction

    // All asynchronous control pins share one synchroniser chain.
`ifdef DSM_DEM_IO_LOOPBACK_EN
    logic s_loop;
    assign sync_in = {pad_loopback, pad_rot, pad_clr, pad_ditheroff, pad_dem_count};
    assign s_loop  = synced[SW-1];
    assign ovfl_en = ~s_loop;
`else
    logic unused_loopback;
    assign sync_in = {pad_rot, pad_clr, pad_ditheroff, pad_dem_count};
    assign unused_loopback = pad_loopback;
    assign ovfl_en = 1'b1;
`endif

    assign synced = sync_q[SYNC_STAGES-1];
    assign s_dem  = synced[1:0];
    assign s_dith = synced[2];
    assign s_clr  = synced[3];
    assign s_rot  = synced[4 +: CW];

    always_ff @(posedge mclk512 or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
            clr_prev <= 1'b0;
        end else begin
            sync_q[0] <= sync_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
            clr_prev <= s_clr;
        end
    end

    assign fs = (frame_cnt == FCW'(FRAME_DIV - 1));

    always_ff @(posedge mclk512 or negedge reset) begin
        if (!reset) begin
            frame_cnt  <= '0;
            core_frame <= 1'b0;
        end else begin
            core_frame <= fs;
            frame_cnt  <= fs ? '0 : frame_cnt + 1'b1;
        end
    end

    // rot_q becomes rot_d at the strobe, so the output path de-rotates with rot_q.
    always_comb begin
        dem_next = '0;
        for (int j = 0; j < NCH; j++) begin
            dem_next[j*OW +: OW] = core_dem_out[wrap_idx(j - int'(rot_q))*OW +: OW];
`ifdef DSM_DEM_IO_LOOPBACK_EN
            if (s_loop)
                dem_next[j*OW +: OW] = in_hold[j*IW + IW - OW +: OW];
`endif
        end
    end

    always_ff @(posedge mclk512 or negedge reset) begin
        if (!reset) begin
            rot_q          <= '0;
            rot_d          <= '0;
            in_hold        <= '0;
            core_ditheroff <= 1'b0;
            core_dem_count <= 2'b00;
            pad_dem_out    <= '0;
        end else if (fs) begin
            rot_d          <= rot_q;
            if (int'(s_rot) < NCH)
                rot_q <= s_rot;
            in_hold        <= pad_chan;
            core_ditheroff <= s_dith;
            core_dem_count <= s_dem;
            pad_dem_out    <= dem_next;
        end
    end

    always_comb begin
        core_chan = '0;
        for (int i = 0; i < NCH; i++)
            core_chan[i*IW +: IW] = in_hold[wrap_idx(i + int'(rot_q))*IW +: IW];
    end

    always_comb begin
        ovfl_set = '0;
        for (int j = 0; j < NCH; j++)
            ovfl_set[j] = core_ovfl[wrap_idx(j - int'(rot_d))];
        if (!ovfl_en)
            ovfl_set = '0;
    end

    assign ovfl_any = |ovfl_set;
    assign clr_edge = s_clr & ~clr_prev;
    assign pad_ovfl = |pad_ovfl_chan;

    // A clear in the same cycle as an overflow still records that overflow.
    always_ff @(posedge mclk512 or negedge reset) begin
        if (!reset) begin
            core_clr      <= 1'b0;
            pad_ovfl_chan <= '0;
            pad_ovfl_cnt  <= '0;
        end else begin
            core_clr <= clr_edge;
            if (clr_edge) begin
                pad_ovfl_chan <= ovfl_set;
                pad_ovfl_cnt  <= CNTW'(ovfl_any);
            end else begin
                pad_ovfl_chan <= pad_ovfl_chan | ovfl_set;
                if (ovfl_any && (pad_ovfl_cnt != '1))
                    pad_ovfl_cnt <= pad_ovfl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsm_dem_io_ctrl.sv
// Scoreboard bench for dsm_dem_io_ctrl: a spec-level model predicts every cycle's
// status and every frame's data; a monitor compares when the DUT presents them.
module tb_dsm_dem_io_ctrl;

    localparam int NCH         = 2;
    localparam int IW          = 24;
    localparam int OW          = 16;
    localparam int FRAME_DIV   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNTW        = 4;
    localparam int CNT_MAX     = 15;

    logic        mclk512       = 1'b0;
    logic        reset         = 1'b0;
    logic [47:0] pad_chan      = '0;
    logic        pad_rot       = 1'b0;
    logic        pad_clr       = 1'b0;
    logic        pad_ditheroff = 1'b0;
    logic [1:0]  pad_dem_count = 2'b00;
    logic        pad_loopback  = 1'b0;
    logic [1:0]  core_ovfl     = '0;
    logic [31:0] core_dem_out  = '0;
    logic [47:0] core_chan;
    logic        core_frame, core_clr, core_ditheroff, pad_ovfl;
    logic [1:0]  core_dem_count, pad_ovfl_chan;
    logic [3:0]  pad_ovfl_cnt;
    logic [31:0] pad_dem_out;

    // Three-channel instance, used to exercise out-of-range rotation requests.
    logic [71:0] pad_chan3     = '0;
    logic [1:0]  pad_rot3      = 2'd0;
    logic [2:0]  core_ovfl3    = '0;
    logic [47:0] core_dem_out3 = '0;
    logic [71:0] core_chan3;
    logic        core_frame3, core_clr3, core_dith3, pad_ovfl3;
    logic [1:0]  core_dem3;
    logic [2:0]  pad_ovfl_chan3;
    logic [3:0]  pad_ovfl_cnt3;
    logic [47:0] pad_dem_out3;

    dsm_dem_io_ctrl #(.NCH(NCH), .IW(IW), .OW(OW), .FRAME_DIV(FRAME_DIV),
                      .SYNC_STAGES(SYNC_STAGES), .CNTW(CNTW)) dut (
        .mclk512(mclk512), .reset(reset), .pad_chan(pad_chan), .pad_rot(pad_rot),
        .pad_clr(pad_clr), .pad_ditheroff(pad_ditheroff), .pad_dem_count(pad_dem_count),
        .pad_loopback(pad_loopback), .core_chan(core_chan), .core_frame(core_frame),
        .core_clr(core_clr), .core_ditheroff(core_ditheroff), .core_dem_count(core_dem_count),
        .core_ovfl(core_ovfl), .core_dem_out(core_dem_out), .pad_ovfl(pad_ovfl),
        .pad_ovfl_chan(pad_ovfl_chan), .pad_ovfl_cnt(pad_ovfl_cnt), .pad_dem_out(pad_dem_out)
    );

    dsm_dem_io_ctrl #(.NCH(3), .IW(IW), .OW(OW), .FRAME_DIV(FRAME_DIV),
                      .SYNC_STAGES(SYNC_STAGES), .CNTW(CNTW)) dut3 (
        .mclk512(mclk512), .reset(reset), .pad_chan(pad_chan3), .pad_rot(pad_rot3),
        .pad_clr(pad_clr), .pad_ditheroff(pad_ditheroff), .pad_dem_count(pad_dem_count),
        .pad_loopback(pad_loopback), .core_chan(core_chan3), .core_frame(core_frame3),
        .core_clr(core_clr3), .core_ditheroff(core_dith3), .core_dem_count(core_dem3),
        .core_ovfl(core_ovfl3), .core_dem_out(core_dem_out3), .pad_ovfl(pad_ovfl3),
        .pad_ovfl_chan(pad_ovfl_chan3), .pad_ovfl_cnt(pad_ovfl_cnt3), .pad_dem_out(pad_dem_out3)
    );

    always #5 mclk512 = ~mclk512;

    int cyc = 0;
    always @(posedge mclk512 or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          edge_n;
        logic [71:0] chan;
        logic [71:0] chan3;
        logic        dith;
        logic [1:0]  dem;
        logic [31:0] dout;
    } frame_exp_t;

    typedef struct {
        int         edge_n;
        logic       frame;
        logic       clr;
        logic [1:0] flags;
        logic [3:0] cnt;
    } stat_exp_t;

    typedef struct packed {
        logic [1:0] rot3;
        logic       rot;
        logic       clr;
        logic       dith;
        logic [1:0] dem;
        logic       loopb;
    } pins_t;

    frame_exp_t frame_q[$];
    stat_exp_t  stat_q[$];
    pins_t      hist[$];

    int total = 0;
    int bad   = 0;

    // Model state, expressed in the spec's own terms.
    int          m_edge, m_rot_q, m_rot_d, m3_rot_q, m_cnt;
    logic [47:0] m_hold;
    logic [71:0] m3_hold;
    logic        m_dith;
    logic [1:0]  m_dem, m_flags;
    logic [31:0] m_out;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [71:0] rotate_in(input logic [71:0] w, input int n, input int r);
        logic [71:0] res;
        res = '0;
        for (int i = 0; i < n; i++)
            res[i*24 +: 24] = w[((i + r) % n)*24 +: 24];
        return res;
    endfunction

    task automatic model_reset();
        m_edge = 0; m_rot_q = 0; m_rot_d = 0; m3_rot_q = 0; m_cnt = 0;
        m_hold = '0; m3_hold = '0; m_dith = 1'b0; m_dem = '0; m_flags = '0; m_out = '0;
        hist.delete();
        for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
    endtask

    // Predicts the DUT after the coming clock edge from the current inputs, then advances.
    task automatic applyStimulus();
        pins_t       now, s_cur, s_prev;
        logic        clr_pulse, loop_on, any;
        logic [1:0]  newbits;
        frame_exp_t  fe;
        stat_exp_t   se;
        m_edge++;
        now    = {pad_rot3, pad_rot, pad_clr, pad_ditheroff, pad_dem_count, pad_loopback};
        s_cur  = hist[SYNC_STAGES-1];
        s_prev = hist[SYNC_STAGES];
        clr_pulse = s_cur.clr && !s_prev.clr;
`ifdef DSM_DEM_IO_LOOPBACK_EN
        loop_on = s_cur.loopb;
`else
        loop_on = 1'b0;
`endif
        newbits = '0;
        if (!loop_on)
            for (int k = 0; k < NCH; k++)
                if (core_ovfl[k]) newbits[(k + m_rot_d) % NCH] = 1'b1;
        any = (newbits != 2'b00);
        if (clr_pulse) begin
            m_flags = newbits;
            m_cnt   = any ? 1 : 0;
        end else begin
            m_flags = m_flags | newbits;
            if (any && m_cnt < CNT_MAX) m_cnt++;
        end
        if (m_edge % FRAME_DIV == 0) begin
            m_rot_d = m_rot_q;
            if (int'(s_cur.rot) < NCH) m_rot_q = int'(s_cur.rot);
            if (int'(s_cur.rot3) < 3) m3_rot_q = int'(s_cur.rot3);
            m_dith = s_cur.dith;
            m_dem  = s_cur.dem;
            for (int j = 0; j < NCH; j++) begin
                if (loop_on) m_out[j*OW +: OW] = m_hold[j*IW + IW - OW +: OW];
                else         m_out[j*OW +: OW] = core_dem_out[((j - m_rot_d + NCH) % NCH)*OW +: OW];
            end
            m_hold  = pad_chan;
            m3_hold = pad_chan3;
            fe.edge_n = m_edge;
            fe.chan   = rotate_in({24'h0, m_hold}, NCH, m_rot_q);
            fe.chan3  = rotate_in(m3_hold, 3, m3_rot_q);
            fe.dith   = m_dith;
            fe.dem    = m_dem;
            fe.dout   = m_out;
            frame_q.push_back(fe);
        end
        se.edge_n = m_edge;
        se.frame  = (m_edge % FRAME_DIV == 0);
        se.clr    = clr_pulse;
        se.flags  = m_flags;
        se.cnt    = 4'(m_cnt);
        stat_q.push_back(se);
        hist.push_front(now);
        void'(hist.pop_back());
        @(negedge mclk512);
    endtask

    stat_exp_t  mon_s;
    frame_exp_t mon_f;

    always @(negedge mclk512) begin
        if (reset) begin
            if (stat_q.size() > 0 && stat_q[0].edge_n == cyc) begin
                mon_s = stat_q.pop_front();
                checkOutput("core_frame", core_frame, mon_s.frame);
                checkOutput("core_clr", core_clr, mon_s.clr);
                checkOutput("pad_ovfl_chan", pad_ovfl_chan, mon_s.flags);
                checkOutput("pad_ovfl", pad_ovfl, |mon_s.flags);
                checkOutput("pad_ovfl_cnt", pad_ovfl_cnt, mon_s.cnt);
            end
            if (core_frame) begin
                if (frame_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL frame_unexpected at cycle %0d: got strobe required none", cyc);
                end else begin
                    mon_f = frame_q.pop_front();
                    checkOutput("frame_cycle", cyc, mon_f.edge_n);
                    checkOutput("core_chan", core_chan, mon_f.chan);
                    checkOutput("core_chan3", core_chan3, mon_f.chan3);
                    checkOutput("core_ditheroff", core_ditheroff, mon_f.dith);
                    checkOutput("core_dem_count", core_dem_count, mon_f.dem);
                    checkOutput("pad_dem_out", pad_dem_out, mon_f.dout);
                end
            end
        end
    end

    task automatic checkResetOutputs(input string name);
        checkOutput(name, {core_chan, core_frame, core_clr, core_ditheroff, core_dem_count,
                           pad_ovfl, pad_ovfl_chan, pad_ovfl_cnt, pad_dem_out}, '0);
        checkOutput({name, "_nch3"}, {core_chan3, core_frame3, core_clr3, pad_dem_out3}, '0);
    endtask

    task automatic randomCycle();
        pad_chan      = {24'($urandom), 24'($urandom)};
        pad_chan3     = {24'($urandom), 24'($urandom), 24'($urandom)};
        core_dem_out  = $urandom;
        pad_rot       = ($urandom_range(0, 3) == 0) ? ~pad_rot : pad_rot;
        pad_rot3      = 2'($urandom_range(0, 3));
        pad_clr       = ($urandom_range(0, 3) == 0) ? ~pad_clr : pad_clr;
        pad_ditheroff = 1'($urandom);
        pad_dem_count = 2'($urandom);
        pad_loopback  = ($urandom_range(0, 7) == 0) ? ~pad_loopback : pad_loopback;
        core_ovfl     = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
        applyStimulus();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        pad_chan  = {24'hABCDEF, 24'h123456};
        pad_chan3 = {24'h333333, 24'h222222, 24'h111111};
        repeat (2) @(negedge mclk512);
        checkResetOutputs("reset_state");
        reset = 1'b1;

        // First frame with rotation 0, then request rotation 1 mid-frame.
        repeat (11) applyStimulus();
        pad_rot      = 1'b1;
        pad_rot3     = 2'd1;
        core_dem_out = {16'h2222, 16'h1111};
        repeat (13) applyStimulus();

        // Single overflow pulse, then a held clear request.
        repeat (3) applyStimulus();
        core_ovfl = 2'b01;
        applyStimulus();
        core_ovfl = 2'b00;
        repeat (2) applyStimulus();
        pad_clr = 1'b1;
        repeat (6) applyStimulus();

        // Saturation, then a clear landing on an overflow cycle.
        core_ovfl = 2'b01;
        repeat (20) applyStimulus();
        core_ovfl = 2'b00;
        pad_clr   = 1'b0;
        repeat (4) applyStimulus();
        pad_clr = 1'b1;
        repeat (2) applyStimulus();
        core_ovfl = 2'b01;
        applyStimulus();
        core_ovfl = 2'b00;
        repeat (3) applyStimulus();

        // Out-of-range rotation on the three-channel instance must be ignored.
        pad_rot3 = 2'd3;
        repeat (16) applyStimulus();

        for (int n = 0; n < 30 * FRAME_DIV; n++) randomCycle();

        // Reset in the middle of a frame.
        while (m_edge % FRAME_DIV != 5) randomCycle();
        #2 reset = 1'b0;
        #1 checkResetOutputs("midframe_reset");
        frame_q.delete();
        stat_q.delete();
        model_reset();
        pad_loopback = 1'b0;
        pad_clr      = 1'b0;
        repeat (2) @(negedge mclk512);
        reset = 1'b1;
        repeat (2 * FRAME_DIV) randomCycle();

        // Loopback request with a recognisable channel-0 word.
        pad_loopback = 1'b1;
        pad_chan     = {24'h0F0F0F, 24'hA5F000};
        core_ovfl    = 2'b11;
        repeat (3 * FRAME_DIV) applyStimulus();
        core_ovfl    = 2'b00;
        pad_loopback = 1'b0;
        repeat (FRAME_DIV) applyStimulus();

        @(negedge mclk512);
        #1;
        checkOutput("pending_frames", frame_q.size(), 0);
        checkOutput("pending_status", stat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
